// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares the physical-memory line port between I-cache and D-cache miss paths; PMEM_ARB_FAIR_EN adds an anti-starvation streak limit for I
module pmem_arbiter #(
  parameter int LINE_WIDTH   = 256,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp,
  output logic                  arb_busy
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;
  logic [1:0] state_q, state_d;
  logic       gi, gd, d_req, starved;
  assign gi    = state_q == SERVE_I;
  assign gd    = state_q == SERVE_D;
  assign d_req = d_pmem_read | d_pmem_write;
`ifdef PMEM_ARB_FAIR_EN
  logic [2:0] streak_q, streak_d;
  assign starved = (streak_q == 3'(STARVE_LIMIT)) && i_pmem_read;
  // count D grants taken over a waiting I; an I grant clears the streak
  always_comb
    streak_d = (state_q == IDLE && state_d == SERVE_I) ? 3'd0 :
               (state_q == IDLE && state_d == SERVE_D && i_pmem_read && streak_q != 3'(STARVE_LIMIT)) ? streak_q + 3'd1 :
               streak_q;
  // streak register shares the async reset of the grant state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) streak_q <= '0;
    else        streak_q <= streak_d;
`else
  assign starved = 1'b0;
`endif
  // grant selection in IDLE (D is older, so it wins); grant held until mem_resp
  always_comb
    state_d = (gi || gd) ? (mem_resp ? IDLE : state_q) :
              starved    ? SERVE_I :
              d_req      ? SERVE_D :
              i_pmem_read ? SERVE_I : IDLE;
  // grant state; reset discards any in-flight transaction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  assign mem_read     = gi | (gd & d_pmem_read & ~d_pmem_write);
  assign mem_write    = gd & d_pmem_write;
  assign mem_address  = gi ? i_pmem_address : gd ? d_pmem_address : '0;
  assign mem_wdata    = gd ? d_pmem_wdata : '0;
  assign i_pmem_resp  = gi & mem_resp;
  assign d_pmem_resp  = gd & mem_resp;
  assign i_pmem_rdata = gi ? mem_rdata : '0;
  assign d_pmem_rdata = gd ? mem_rdata : '0;
  assign arb_busy     = state_q != IDLE;
endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: directed and randomized checks of pmem_arbiter against a grant-ownership model
module tb_pmem_arbiter;
`ifdef PMEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  localparam int LIMIT = 4;
  logic clk = 0, rst_n = 0;
  logic i_pmem_read = 0, d_pmem_read = 0, d_pmem_write = 0, mem_resp = 0;
  logic [31:0] i_pmem_address = 0, d_pmem_address = 0, mem_address;
  logic [255:0] d_pmem_wdata = 0, mem_rdata = 0, i_pmem_rdata, d_pmem_rdata, mem_wdata;
  logic i_pmem_resp, d_pmem_resp, mem_read, mem_write, arb_busy;
  int pass = 0, total = 0;
  pmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .arb_busy(arb_busy)
  );
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // model: who owns the memory port (0 none, 1 I-cache, 2 D-cache) plus D-over-I streak
  int own = 0, streak = 0;
  logic i_got = 0, d_got = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      own = 0;
      streak = 0;
    end
    chk("mem_read", mem_read, own == 1 || (own == 2 && d_pmem_read && !d_pmem_write));
    chk("mem_write", mem_write, own == 2 && d_pmem_write);
    chk("mem_address", mem_address, own == 1 ? i_pmem_address : own == 2 ? d_pmem_address : 32'h0);
    chk("mem_wdata", mem_wdata, own == 2 ? d_pmem_wdata : 256'h0);
    chk("i_resp", i_pmem_resp, own == 1 && mem_resp);
    chk("d_resp", d_pmem_resp, own == 2 && mem_resp);
    chk("i_rdata", i_pmem_rdata, own == 1 ? mem_rdata : 256'h0);
    chk("d_rdata", d_pmem_rdata, own == 2 ? mem_rdata : 256'h0);
    chk("arb_busy", arb_busy, own != 0);
    i_got = i_pmem_resp;
    d_got = d_pmem_resp;
    if (rst_n) begin
      if (own != 0) begin
        if (mem_resp) own = 0;
      end else if (FAIR && streak == LIMIT && i_pmem_read) begin
        own = 1;
        streak = 0;
      end else if (d_pmem_read || d_pmem_write) begin
        own = 2;
        if (i_pmem_read && streak < LIMIT) streak++;
      end else if (i_pmem_read) begin
        own = 1;
        streak = 0;
      end
    end
  end

  logic [11:0] seq;
  int n;
  initial begin
    // 1: reset with both requesting, then D granted one cycle after release
    i_pmem_read = 1; d_pmem_read = 1; i_pmem_address = 32'h100; d_pmem_address = 32'h200;
    tick(); tick();
    chk("rst mem_read", mem_read, 0);
    chk("rst mem_write", mem_write, 0);
    chk("rst busy", arb_busy, 0);
    chk("rst addr", mem_address, 0);
    rst_n = 1;
    tick();
    chk("t1 mem_read", mem_read, 1);
    chk("t1 addr", mem_address, 32'h200);
    mem_resp = 1;
    tick();
    mem_resp = 0; d_pmem_read = 0; i_pmem_read = 0;
    tick();
    // 2: lone I fill
    i_pmem_read = 1; i_pmem_address = 32'h0000_1040;
    tick();
    chk("t2 mem_read", mem_read, 1);
    chk("t2 addr", mem_address, 32'h0000_1040);
    tick(); tick();
    mem_resp = 1; mem_rdata = {32{8'hA5}};
    #1;
    chk("t2 i_resp", i_pmem_resp, 1);
    chk("t2 i_rdata", i_pmem_rdata, {32{8'hA5}});
    chk("t2 d_resp", d_pmem_resp, 0);
    tick();
    mem_resp = 0; i_pmem_read = 0;
    chk("t2 idle", arb_busy, 0);
    tick();
    // 3: simultaneous I and D reads
    i_pmem_read = 1; i_pmem_address = 32'h3000; d_pmem_read = 1; d_pmem_address = 32'h4000;
    tick();
    chk("t3 d first", mem_address, 32'h4000);
    mem_resp = 1;
    tick();
    mem_resp = 0; d_pmem_read = 0;
    chk("t3 gap", arb_busy, 0);
    chk("t3 gap strobe", mem_read, 0);
    tick();
    chk("t3 i next", mem_address, 32'h3000);
    mem_resp = 1;
    tick();
    mem_resp = 0; i_pmem_read = 0;
    tick();
    // 4: writeback then fill
    d_pmem_write = 1; d_pmem_address = 32'h5000; d_pmem_wdata = {32{8'hDE}};
    tick();
    chk("t4 write", mem_write, 1);
    chk("t4 no read", mem_read, 0);
    chk("t4 wdata", mem_wdata, {32{8'hDE}});
    mem_resp = 1;
    tick();
    mem_resp = 0; d_pmem_write = 0; d_pmem_read = 1;
    tick();
    chk("t4 fill read", mem_read, 1);
    chk("t4 fill write", mem_write, 0);
    mem_resp = 1;
    tick();
    mem_resp = 0; d_pmem_read = 0;
    tick();
    // 5: reset mid I transaction
    i_pmem_read = 1; i_pmem_address = 32'h6000;
    tick();
    chk("t5 read", mem_read, 1);
    rst_n = 0; mem_resp = 1;
    #1;
    chk("t5 drop", mem_read, 0);
    chk("t5 no resp", i_pmem_resp, 0);
    tick();
    rst_n = 1; mem_resp = 0; i_pmem_read = 0;
    tick();
    chk("t5 idle", arb_busy, 0);
    // 6: I and D both held continuously; fairness shapes grant order
    rst_n = 0; #1;
    i_pmem_read = 1; d_pmem_read = 1; mem_resp = 1;
    tick();
    rst_n = 1;
    seq = 0; n = 0;
    for (int k = 0; k < 24; k++) begin
      tick();
      if ((i_pmem_resp || d_pmem_resp) && n < 12) begin
        seq[n] = i_pmem_resp;
        n++;
      end
    end
    chk("t6 grants", 32'(n), 32'd12);
    chk("t6 order", seq, FAIR ? 12'h210 : 12'h000);
    i_pmem_read = 0; d_pmem_read = 0; mem_resp = 0;
    tick(); tick();
    // random traffic checked by the model every cycle
    for (int k = 0; k < 3000; k++) begin
      tick();
      if (i_got) i_pmem_read = 0;
      else if (!i_pmem_read && $urandom_range(2) == 0) begin
        i_pmem_read = 1;
        i_pmem_address = $urandom;
      end
      if (d_got) begin
        d_pmem_read = 0;
        d_pmem_write = 0;
      end else if (!d_pmem_read && !d_pmem_write && $urandom_range(2) == 0) begin
        case ($urandom_range(7))
          0: begin d_pmem_read = 1; d_pmem_write = 1; end
          1, 2, 3: d_pmem_write = 1;
          default: d_pmem_read = 1;
        endcase
        d_pmem_address = $urandom;
        d_pmem_wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
      mem_resp = $urandom_range(2) == 0;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    end
    tick();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
